// File: rtl/ex_alu_pkg.sv
// ---------------------------------------------------------------------------
// ex_alu_pkg
// Shared definitions for the s3_execute ALU sequencer:
//   - alu_op_e      : 4-bit operation code, all 16 values meaningful
//   - U_* indices   : bit positions of the 13 gated op units in the enable vector
//   - seq_state_e   : sequencer state encoding
// Optional feature macro: ALU_SERIAL_SHIFT_EN adds the SHIFT state.
// ---------------------------------------------------------------------------
package ex_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_XOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_BLTU = 4'd14,
        OP_BGEU = 4'd15
    } alu_op_e;

    // Positions of the op units inside the one-hot enable vector
    localparam int U_ADD     = 0;
    localparam int U_SUB     = 1;
    localparam int U_XOR     = 2;
    localparam int U_OR      = 3;
    localparam int U_AND     = 4;
    localparam int U_SLL     = 5;
    localparam int U_SRL     = 6;
    localparam int U_SRA     = 7;
    localparam int U_SLT     = 8;
    localparam int U_SLTU    = 9;
    localparam int U_EQ      = 10;
    localparam int U_GE      = 11;
    localparam int U_GEU     = 12;
    localparam int NUM_UNITS = 13;

`ifdef ALU_SERIAL_SHIFT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_SHIFT = 2'd2
    } seq_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1
    } seq_state_e;
`endif

endpackage

// File: rtl/ex_alu_dec.sv
// ---------------------------------------------------------------------------
// ex_alu_dec
// Purely combinational decoder: op code -> one-hot unit enable, plus the
// branch flag and the result-invert flag (BNE reuses the eq unit inverted).
// Ports:
//   i_valid  : high in a computing cycle; all enables are 0 otherwise
//   i_op     : op code (alu_op_e encoding)
//   o_en     : one-hot unit enable, NUM_UNITS wide
//   o_is_br  : op is a branch compare
//   o_inv    : invert the selected compare unit's result
// ---------------------------------------------------------------------------
module ex_alu_dec
    import ex_alu_pkg::*;
(
    input  logic                 i_valid,
    input  logic [3:0]           i_op,
    output logic [NUM_UNITS-1:0] o_en,
    output logic                 o_is_br,
    output logic                 o_inv
);

    logic [NUM_UNITS-1:0] w_onehot;

    // Map every op code onto exactly one unit; branches share the compare units
    always_comb begin
        w_onehot = '0;
        o_is_br  = 1'b0;
        o_inv    = 1'b0;
        case (alu_op_e'(i_op))
            OP_ADD:  w_onehot[U_ADD]  = 1'b1;
            OP_SUB:  w_onehot[U_SUB]  = 1'b1;
            OP_XOR:  w_onehot[U_XOR]  = 1'b1;
            OP_OR:   w_onehot[U_OR]   = 1'b1;
            OP_AND:  w_onehot[U_AND]  = 1'b1;
            OP_SLL:  w_onehot[U_SLL]  = 1'b1;
            OP_SRL:  w_onehot[U_SRL]  = 1'b1;
            OP_SRA:  w_onehot[U_SRA]  = 1'b1;
            OP_SLT:  w_onehot[U_SLT]  = 1'b1;
            OP_SLTU: w_onehot[U_SLTU] = 1'b1;
            OP_BEQ: begin
                w_onehot[U_EQ] = 1'b1;
                o_is_br        = 1'b1;
            end
            OP_BNE: begin
                w_onehot[U_EQ] = 1'b1;
                o_is_br        = 1'b1;
                o_inv          = 1'b1;
            end
            OP_BLT: begin
                w_onehot[U_SLT] = 1'b1;
                o_is_br         = 1'b1;
            end
            OP_BGE: begin
                w_onehot[U_GE] = 1'b1;
                o_is_br        = 1'b1;
            end
            OP_BLTU: begin
                w_onehot[U_SLTU] = 1'b1;
                o_is_br          = 1'b1;
            end
            OP_BGEU: begin
                w_onehot[U_GEU] = 1'b1;
                o_is_br         = 1'b1;
            end
            default: w_onehot = '0;
        endcase
    end

    assign o_en = i_valid ? w_onehot : '0;

endmodule

// File: rtl/ex_alu_seq.sv
// ---------------------------------------------------------------------------
// ex_alu_seq
// Execute-stage ALU sequencer. Accepts one op per in_valid/in_ready handshake,
// enables exactly one gated op unit, OR-merges the unit outputs and registers
// result / branch-taken / tag behind an out_valid/out_ready handshake.
// Configuration macro: ALU_SERIAL_SHIFT_EN
//   defined   : SLL/SRL/SRA shift one bit per cycle (SHIFT state), no barrel units
//   undefined : shifts use barrel units, latency 1
// Ports:
//   i_clk, i_rst_n (async active-low), i_flush (sync kill)
//   i_in_valid / o_in_ready, i_in_op, i_in_a, i_in_b, i_in_tag : op input
//   o_out_valid / i_out_ready, o_out_res, o_out_taken, o_out_is_br, o_out_tag
// ---------------------------------------------------------------------------
module ex_alu_seq
    import ex_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_in_op,
    input  logic [XLEN-1:0]  i_in_a,
    input  logic [XLEN-1:0]  i_in_b,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_out_res,
    output logic             o_out_taken,
    output logic             o_out_is_br,
    output logic [TAG_W-1:0] o_out_tag
);

    seq_state_e           r_state;
    seq_state_e           w_next;
    seq_state_e           w_load_state;

    logic                 w_accept;
    logic [NUM_UNITS-1:0] w_en;
    logic                 w_is_br;
    logic                 w_inv;
    logic [4:0]           w_shamt;
    logic [XLEN-1:0]      w_unit [NUM_UNITS];
    logic [XLEN-1:0]      w_merged;
    logic [XLEN-1:0]      w_res;
    logic                 w_cmp;
    logic                 w_taken;

    logic [XLEN-1:0]      r_res;
    logic                 r_taken;
    logic                 r_is_br;
    logic [TAG_W-1:0]     r_tag;

`ifdef ALU_SERIAL_SHIFT_EN
    logic                 w_is_shift;
    logic                 w_start_serial;
    logic [XLEN-1:0]      w_bypass;
    logic [XLEN-1:0]      r_shreg;
    logic [4:0]           r_cnt;
    alu_op_e              r_shop;
`endif

    assign w_shamt  = i_in_b[4:0];
    assign w_accept = i_in_valid & o_in_ready;

    ex_alu_dec u_dec (
        .i_valid (w_accept),
        .i_op    (i_in_op),
        .o_en    (w_en),
        .o_is_br (w_is_br),
        .o_inv   (w_inv)
    );

`ifdef ALU_SERIAL_SHIFT_EN
    // Nonzero shifts go to the serial engine; a zero shift is just operand a
    assign w_is_shift     = w_en[U_SLL] | w_en[U_SRL] | w_en[U_SRA];
    assign w_start_serial = w_is_shift & (w_shamt != 5'd0);
    assign w_bypass       = (w_is_shift && (w_shamt == 5'd0)) ? i_in_a : '0;
    assign w_load_state   = w_start_serial ? ST_SHIFT : ST_VALID;
`else
    assign w_load_state   = ST_VALID;
`endif

    // Gated op units: each output is zero unless its enable is high
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_unit[i] = '0;
        end
        if (w_en[U_ADD])  w_unit[U_ADD]  = i_in_a + i_in_b;
        if (w_en[U_SUB])  w_unit[U_SUB]  = i_in_a - i_in_b;
        if (w_en[U_XOR])  w_unit[U_XOR]  = i_in_a ^ i_in_b;
        if (w_en[U_OR])   w_unit[U_OR]   = i_in_a | i_in_b;
        if (w_en[U_AND])  w_unit[U_AND]  = i_in_a & i_in_b;
`ifndef ALU_SERIAL_SHIFT_EN
        if (w_en[U_SLL])  w_unit[U_SLL]  = i_in_a << w_shamt;
        if (w_en[U_SRL])  w_unit[U_SRL]  = i_in_a >> w_shamt;
        if (w_en[U_SRA])  w_unit[U_SRA]  = $signed(i_in_a) >>> w_shamt;
`endif
        if (w_en[U_SLT])  w_unit[U_SLT]  = {{(XLEN-1){1'b0}}, ($signed(i_in_a) <  $signed(i_in_b))};
        if (w_en[U_SLTU]) w_unit[U_SLTU] = {{(XLEN-1){1'b0}}, (i_in_a <  i_in_b)};
        if (w_en[U_EQ])   w_unit[U_EQ]   = {{(XLEN-1){1'b0}}, (i_in_a == i_in_b)};
        if (w_en[U_GE])   w_unit[U_GE]   = {{(XLEN-1){1'b0}}, ($signed(i_in_a) >= $signed(i_in_b))};
        if (w_en[U_GEU])  w_unit[U_GEU]  = {{(XLEN-1){1'b0}}, (i_in_a >= i_in_b)};
    end

    // One-hot enables make a plain OR a correct result mux
    always_comb begin
        w_merged = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_merged = w_merged | w_unit[i];
        end
    end

    // Branches report their (possibly inverted) compare bit as both result and taken
    assign w_cmp   = w_merged[0] ^ w_inv;
    assign w_taken = w_is_br & w_cmp;
`ifdef ALU_SERIAL_SHIFT_EN
    assign w_res   = w_is_br ? {{(XLEN-1){1'b0}}, w_cmp} : (w_merged | w_bypass);
`else
    assign w_res   = w_is_br ? {{(XLEN-1){1'b0}}, w_cmp} : w_merged;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs; flush wins over any accept
    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = (r_state == ST_VALID);
        if (!i_flush) begin
            case (r_state)
                ST_IDLE:  o_in_ready = 1'b1;
                ST_VALID: o_in_ready = i_out_ready;
                default:  o_in_ready = 1'b0;
            endcase
        end
        if (i_flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_next = w_load_state;
                end
                ST_VALID: begin
                    if (i_out_ready) w_next = i_in_valid ? w_load_state : ST_IDLE;
                end
`ifdef ALU_SERIAL_SHIFT_EN
                ST_SHIFT: begin
                    if (r_cnt == 5'd0) w_next = ST_VALID;
                end
`endif
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Result registers; the serial engine shifts while the count is nonzero
    // and copies its register into the result on the final SHIFT cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res   <= '0;
            r_taken <= 1'b0;
            r_is_br <= 1'b0;
            r_tag   <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
            r_shreg <= '0;
            r_cnt   <= 5'd0;
            r_shop  <= OP_ADD;
`endif
        end else if (i_flush) begin
            r_res   <= '0;
            r_taken <= 1'b0;
            r_is_br <= 1'b0;
            r_tag   <= '0;
`ifdef ALU_SERIAL_SHIFT_EN
            r_shreg <= '0;
            r_cnt   <= 5'd0;
`endif
        end else if (w_accept) begin
            r_res   <= w_res;
            r_taken <= w_taken;
            r_is_br <= w_is_br;
            r_tag   <= i_in_tag;
`ifdef ALU_SERIAL_SHIFT_EN
            if (w_start_serial) begin
                r_shreg <= i_in_a;
                r_cnt   <= w_shamt;
                r_shop  <= alu_op_e'(i_in_op);
            end
`endif
        end
`ifdef ALU_SERIAL_SHIFT_EN
        else if (r_state == ST_SHIFT) begin
            if (r_cnt != 5'd0) begin
                r_cnt <= r_cnt - 5'd1;
                case (r_shop)
                    OP_SLL:  r_shreg <= r_shreg << 1;
                    OP_SRL:  r_shreg <= r_shreg >> 1;
                    default: r_shreg <= {r_shreg[XLEN-1], r_shreg[XLEN-1:1]};
                endcase
            end else begin
                r_res <= r_shreg;
            end
        end
`endif
    end

    assign o_out_res   = r_res;
    assign o_out_taken = r_taken;
    assign o_out_is_br = r_is_br;
    assign o_out_tag   = r_tag;

endmodule
